cdb_arbiter: RTL and testbench

- Shares the single Common Data Bus (CDB) among N functional units (adder, multiplier, load unit, …).
- Each unit raises `CDB_rts` when it has a result and waits for its `CDB_xmit`. The arbiter grants at most one unit per cycle, round-robin.
- It captures the granted unit's `CDB_data`/`CDB_source`/`CDB_write` and broadcasts them, registered, to the reservation stations and register file.
- It flags protocol violations on a sticky `error`.

---
 rtl/cdb_arbiter_pkg.sv | 19 +
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter_rr.sv | 39 +++
 rtl/cdb_arbiter.sv | 87 ++++++++
 tb/tb_cdb_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: default bus geometry and the broadcast message type
// used by the arbiter, the functional units and the reservation stations.
package cdb_pkg;

  localparam int CDB_N_UNITS = 4;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_TAG_W   = 6;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  source;
    logic [CDB_DATA_W-1:0] data;
  } cdb_msg_t;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit request/grant signals and the registered CDB broadcast.
// The master side is the arbiter; the slave side is the units plus the downstream consumer.
interface cdb_arbiter_if #(
  parameter int N_UNITS = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6
);

  logic [N_UNITS-1:0]             unit_rts;
  logic [N_UNITS-1:0][DATA_W-1:0] unit_data;
  logic [N_UNITS-1:0][TAG_W-1:0]  unit_source;
  logic [N_UNITS-1:0]             unit_write;
  logic                           cdb_hold;
  logic [N_UNITS-1:0]             unit_xmit;
  logic [DATA_W-1:0]              cdb_data;
  logic [TAG_W-1:0]               cdb_source;
  logic                           cdb_valid;

  modport master (
    input  unit_rts, unit_data, unit_source, unit_write, cdb_hold,
    output unit_xmit, cdb_data, cdb_source, cdb_valid
  );

  modport slave (
    output unit_rts, unit_data, unit_source, unit_write, cdb_hold,
    input  unit_xmit, cdb_data, cdb_source, cdb_valid
  );

endinterface

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: rotate the request vector so ptr sits at
// bit 0, take the lowest set bit, then rotate the winner back to unit numbering.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [N-1:0]  rot;
  logic [IW-1:0] rot_idx;

  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req[(int'(ptr) + j) % N];
    end
  end

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    rot_idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) rot_idx = IW'(j);
    end
  end

  always_comb begin
    any       = |req;
    grant_idx = IW'((int'(rot_idx) + int'(ptr)) % N);
    grant     = '0;
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant of one functional unit per cycle, registered
// broadcast of the granted unit's result, and a sticky protocol-error flag.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter  int N_UNITS = CDB_N_UNITS,
  parameter  int DATA_W  = CDB_DATA_W,
  parameter  int TAG_W   = CDB_TAG_W,
  localparam int IW      = $clog2(N_UNITS)
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.master bus,
  output logic          error,
  output logic [IW-1:0] error_unit
);

  logic [IW-1:0]      ptr;
  logic [N_UNITS-1:0] elig;
  logic [N_UNITS-1:0] win;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic [IW-1:0]      grant_idx;
  logic [N_UNITS-1:0] viol;
  logic [IW-1:0]      viol_idx;

  // A unit holding the grant this cycle sits out the next pick.
  assign elig = bus.unit_rts & ~bus.unit_xmit;

  rr_arbiter #(.N(N_UNITS)) u_rr (
    .req       (elig),
    .ptr       (ptr),
    .grant     (win),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (bus.unit_xmit[i]) grant_idx = IW'(i);
    end
  end

  // Grant without write and write without grant both reduce to xmit != write.
  assign viol = bus.unit_xmit ^ bus.unit_write;

  always_comb begin
    viol_idx = '0;
    for (int i = N_UNITS - 1; i >= 0; i--) begin
      if (viol[i]) viol_idx = IW'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr            <= '0;
      bus.unit_xmit  <= '0;
      bus.cdb_data   <= '0;
      bus.cdb_source <= '0;
      bus.cdb_valid  <= 1'b0;
      error          <= 1'b0;
      error_unit     <= '0;
    end else begin
      if (!bus.cdb_hold && win_any) begin
        bus.unit_xmit <= win;
        ptr           <= IW'(wrap_inc(32'(win_idx), N_UNITS));
      end else begin
        bus.unit_xmit <= '0;
      end

      if (|bus.unit_xmit) begin
        bus.cdb_data   <= bus.unit_data[grant_idx];
        bus.cdb_source <= bus.unit_source[grant_idx];
        bus.cdb_valid  <= bus.unit_write[grant_idx];
      end else begin
        bus.cdb_valid  <= 1'b0;
      end

      if (!error && (|viol)) begin
        error      <= 1'b1;
        error_unit <= viol_idx;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: each unit answers its grant with a fixed
// result (data 10*(i+1), tag i+1) unless a test suppresses or forces its write.
module tb_cdb_arbiter;

  localparam int N = 4;
  localparam int DW = 32;
  localparam int TW = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic       error;
  logic [1:0] error_unit;
  logic [N-1:0] no_write;
  logic [N-1:0] force_write;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter_if #(.N_UNITS(N), .DATA_W(DW), .TAG_W(TW)) bus ();

  cdb_arbiter #(.N_UNITS(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .error      (error),
    .error_unit (error_unit)
  );

  always #5 clock = ~clock;

  assign bus.unit_write = (bus.unit_xmit & ~no_write) | force_write;
  for (genvar i = 0; i < N; i++) begin : g_unit
    assign bus.unit_data[i]   = DW'(10 * (i + 1));
    assign bus.unit_source[i] = TW'(i + 1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.unit_rts = '0;
    bus.cdb_hold = 1'b0;
    no_write     = '0;
    force_write  = '0;
    reset        = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [3:0] rr_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    do_reset();
    chk("rst_xmit", 32'(bus.unit_xmit), 0);
    chk("rst_valid", 32'(bus.cdb_valid), 0);
    chk("rst_data", bus.cdb_data, 0);
    chk("rst_error", 32'(error), 0);

    // single requester: served every other cycle
    bus.unit_rts = 4'b0001;
    tick();
    chk("single_grant", 32'(bus.unit_xmit), 32'b0001);
    chk("single_nobcast", 32'(bus.cdb_valid), 0);
    tick();
    chk("single_gap", 32'(bus.unit_xmit), 0);
    chk("single_valid", 32'(bus.cdb_valid), 1);
    chk("single_src", 32'(bus.cdb_source), 1);
    chk("single_data", bus.cdb_data, 10);
    tick();
    chk("single_regrant", 32'(bus.unit_xmit), 32'b0001);
    bus.unit_rts = '0;
    tick();
    chk("single_valid2", 32'(bus.cdb_valid), 1);
    chk("single_idle", 32'(bus.unit_xmit), 0);

    // all four request together from reset
    do_reset();
    bus.unit_rts = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_grant%0d", k), 32'(bus.unit_xmit), 32'(rr_grant[k]));
      if (k > 0) begin
        chk($sformatf("rr_valid%0d", k), 32'(bus.cdb_valid), 1);
        chk($sformatf("rr_data%0d", k), bus.cdb_data, 32'(10 * k));
      end
    end
    bus.unit_rts = '0;
    tick();
    chk("rr_last_data", bus.cdb_data, 10);
    chk("rr_err", 32'(error), 0);

    // reset in unit 1's grant cycle (ptr is 1, last data 10)
    bus.unit_rts = 4'b0010;
    tick();
    chk("mid_grant", 32'(bus.unit_xmit), 32'b0010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_xmit", 32'(bus.unit_xmit), 0);
    chk("mid_valid", 32'(bus.cdb_valid), 0);
    chk("mid_data", bus.cdb_data, 0);
    chk("mid_src", 32'(bus.cdb_source), 0);
    tick();
    chk("mid_regrant", 32'(bus.unit_xmit), 32'b0010);

    // hold: blocks new grants, lets a visible grant complete
    do_reset();
    bus.unit_rts = 4'b0110;
    bus.cdb_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold_block%0d", k), 32'(bus.unit_xmit), 0);
    end
    bus.cdb_hold = 1'b0;
    tick();
    chk("hold_first", 32'(bus.unit_xmit), 32'b0010);
    bus.cdb_hold = 1'b1;
    tick();
    chk("hold_cut", 32'(bus.unit_xmit), 0);
    chk("hold_cap_valid", 32'(bus.cdb_valid), 1);
    chk("hold_cap_data", bus.cdb_data, 20);
    tick();
    chk("hold_idle_valid", 32'(bus.cdb_valid), 0);
    chk("hold_keep_data", bus.cdb_data, 20);
    tick();
    chk("hold_idle_xmit", 32'(bus.unit_xmit), 0);
    bus.cdb_hold = 1'b0;
    tick();
    chk("hold_release", 32'(bus.unit_xmit), 32'b0100);
    tick();
    chk("hold_next", 32'(bus.unit_xmit), 32'b0010);
    chk("hold_next_data", bus.cdb_data, 30);

    // grant without write
    do_reset();
    no_write     = 4'b0100;
    bus.unit_rts = 4'b0100;
    tick();
    chk("nw_grant", 32'(bus.unit_xmit), 32'b0100);
    bus.unit_rts = '0;
    tick();
    chk("nw_error", 32'(error), 1);
    chk("nw_unit", 32'(error_unit), 2);
    chk("nw_valid", 32'(bus.cdb_valid), 0);
    force_write = 4'b0001;
    tick();
    tick();
    chk("nw_sticky", 32'(error), 1);
    chk("nw_keep_unit", 32'(error_unit), 2);

    // write without grant
    do_reset();
    chk("wng_clear", 32'(error), 0);
    force_write = 4'b1000;
    tick();
    chk("wng_error", 32'(error), 1);
    chk("wng_unit", 32'(error_unit), 3);
    force_write = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
